alu16: RTL and testbench
========================

# alu16

Sixteen-bit integer ALU for the nqcpu datapath. It computes add, subtract, multiply, divide and bitwise logic on two 16-bit operands selected by a 4-bit opcode. Result and flags are registered and available one clock after the operands are presented. The execute stage consumes the result and the zero/carry flags; the flags feed the branch logic.

## Interface

Reset is asynchronous and active-low; the design has a single clock.

Parameters: none. Data width is fixed at 16 bits.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  4  operation select
- x  in  16  operand A (left operand, dividend, minuend)
- y  in  16  operand B (right operand, divisor, subtrahend)
- result  out  16  registered operation result
- zero  out  1  registered; 1 when the computed result is 0x0000
- carry  out  1  registered carry/borrow flag

## Operation

- op 0x0 ADD: result = (x + y)[15:0]; carry = bit 16 of the 17-bit sum.
- op 0x1 SUB: result = (x − y)[15:0]; carry = 1 when y > x (unsigned borrow), else 0.
- op 0x2 MUL: result = low 16 bits of the unsigned 32-bit product; high bits are discarded; carry = 0.
- op 0x3 DIV: result = unsigned floor(x / y); carry = 0.
  - Divide by zero (y = 0): result = 0xFFFF, carry = 1.
- op 0x4 AND: result = x & y; carry = 0.
- op 0x5 OR: result = x | y; carry = 0.
- op 0x6 XOR: result = x ^ y; carry = 0.
- op 0x7–0xF reserved: result = 0x0000, carry = 0.
- zero is derived from the final 16-bit result for every op, including reserved ops, where zero = 1.
- All arithmetic is unsigned and wraps modulo 2^16. There are no sign or overflow flags.

## Timing

- Result, zero and carry are computed combinationally from op, x and y. They are captured into output registers on every rising edge of clk.
- Latency is exactly 1 cycle: inputs stable before edge N appear on the outputs after edge N.
- Throughput is one operation per cycle. There is no handshake, stall or busy signal; the divider is single-cycle combinational.
- Reset: when rst_n is low, the outputs immediately become result = 0x0000, zero = 1, carry = 0, independent of clk.
- On release of rst_n, the first rising edge captures the current inputs.
- Reset asserted mid-stream discards the pending computation. There is no other state.
- Inputs changing between edges have no effect on the outputs until the next edge.

## Configuration

- Macro `ALU_DIV_EN`.
- Defined: the divider is built and op 0x3 behaves as specified above.
- Not defined: no divider logic is synthesized. op 0x3 behaves as a reserved op: result = 0x0000, zero = 1, carry = 0.

## Test plan

- Reset: hold rst_n low with arbitrary inputs -> result 0x0000, zero 1, carry 0. Release rst_n, apply x=0x0123, y=0x1234, op=0x0, then one edge -> result 0x1357, zero 0, carry 0.
- Subtract: x=0x0123, y=0x1234, op=0x1 -> 0xEEEF, carry 1, zero 0. Then y=0x0123 -> 0x0000, zero 1, carry 0. Also ADD 0xFFFF+0x0001 -> 0x0000, zero 1, carry 1.
- Multiply: x=0x0123, y=0x1234, op=0x2 -> 0xB11C, zero 0, carry 0 (product truncated).
- Divide (with `ALU_DIV_EN` defined): x=0x3E58, y=0x0078, op=0x3 -> 0x0085, carry 0. Then y=0x0000 -> 0xFFFF, carry 1. With the macro undefined, op=0x3 -> 0x0000, zero 1.
- Logic: x=0xAF74, y=0x7CC7 -> op 0x4 gives 0x2C44, op 0x5 gives 0xFFF7, op 0x6 gives 0xD3B3; carry 0 for each. Any op in 0x7–0xF -> 0x0000, zero 1.
- Latency and reset: change ops on every cycle and check each output appears exactly one edge later. Assert rst_n mid-sequence -> outputs return to reset values at once, without waiting for an edge.

Source files
------------

// File: rtl/alu16.sv
//------------------------------------------------------------------------------
// Module   : alu16
// Purpose  : Sixteen-bit unsigned integer ALU for the nqcpu datapath.
//            Computes ADD, SUB, MUL, DIV and bitwise logic on two 16-bit
//            operands selected by a 4-bit opcode. The result, zero flag and
//            carry/borrow flag are computed combinationally and captured into
//            output registers, so each result appears exactly one clock after
//            its operands.
// Config   : `ALU_DIV_EN - when defined, the single-cycle combinational
//            divider is built and op 0x3 performs unsigned division. When it is
//            not defined, no divider logic exists and op 0x3 behaves like a
//            reserved opcode.
// Ports    :
//   clk     in   1   system clock, rising edge active
//   rst_n   in   1   asynchronous active-low reset
//   op      in   4   operation select
//   x       in  16   operand A (left operand, dividend, minuend)
//   y       in  16   operand B (right operand, divisor, subtrahend)
//   result  out 16   registered operation result
//   zero    out  1   registered, 1 when the result is 0x0000
//   carry   out  1   registered carry (ADD) / borrow (SUB) / div-by-zero flag
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  op,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] result,
  output logic        zero,
  output logic        carry
);

  // Opcode encoding
  localparam logic [3:0] c_OP_ADD = 4'h0;
  localparam logic [3:0] c_OP_SUB = 4'h1;
  localparam logic [3:0] c_OP_MUL = 4'h2;
  localparam logic [3:0] c_OP_DIV = 4'h3;
  localparam logic [3:0] c_OP_AND = 4'h4;
  localparam logic [3:0] c_OP_OR  = 4'h5;
  localparam logic [3:0] c_OP_XOR = 4'h6;

  // Reset values of the output registers
  localparam logic [15:0] c_RESULT_RST = 16'h0000;
  localparam logic        c_ZERO_RST   = 1'b1;
  localparam logic        c_CARRY_RST  = 1'b0;

  //--------------------------------------------------------------------------
  // Arithmetic datapath
  //--------------------------------------------------------------------------
  logic [16:0] w_sum;
  logic [16:0] w_diff;
  logic [15:0] w_prod;

  // Both operands are zero-extended to 17 bits: bit 16 of the sum is the
  // carry-out, and bit 16 of the difference is set exactly when y > x.
  assign w_sum  = {1'b0, x} + {1'b0, y};
  assign w_diff = {1'b0, x} - {1'b0, y};
  // Only the low half of the product is architecturally visible.
  assign w_prod = x * y;

`ifdef ALU_DIV_EN
  //--------------------------------------------------------------------------
  // Single-cycle restoring divider (unsigned)
  //--------------------------------------------------------------------------
  logic [15:0] w_quot;
  logic        w_div_by_zero;

  assign w_div_by_zero = (y == 16'h0000);

  // Unrolled restoring division: one trial subtraction per quotient bit,
  // MSB first. The partial remainder is kept 17 bits wide so the shifted
  // value never overflows before the compare.
  always_comb begin : p_div
    logic [16:0] v_rem;
    w_quot = 16'h0000;
    v_rem  = 17'h00000;
    for (int i = 15; i >= 0; i--) begin
      v_rem = {v_rem[15:0], x[i]};
      if (v_rem >= {1'b0, y}) begin
        v_rem     = v_rem - {1'b0, y};
        w_quot[i] = 1'b1;
      end
    end
  end
`endif

  //--------------------------------------------------------------------------
  // Operation select
  //--------------------------------------------------------------------------
  logic [15:0] w_result;
  logic        w_carry;
  logic        w_zero;

  always_comb begin
    w_result = 16'h0000;
    w_carry  = 1'b0;
    case (op)
      c_OP_ADD: begin
        w_result = w_sum[15:0];
        w_carry  = w_sum[16];
      end
      c_OP_SUB: begin
        w_result = w_diff[15:0];
        w_carry  = w_diff[16];
      end
      c_OP_MUL: begin
        w_result = w_prod;
      end
`ifdef ALU_DIV_EN
      c_OP_DIV: begin
        // Division by zero saturates the quotient and raises carry.
        if (w_div_by_zero) begin
          w_result = 16'hFFFF;
          w_carry  = 1'b1;
        end else begin
          w_result = w_quot;
        end
      end
`else
      c_OP_DIV: begin
        // Divider not built: behaves as a reserved opcode.
        w_result = 16'h0000;
      end
`endif
      c_OP_AND: w_result = x & y;
      c_OP_OR:  w_result = x | y;
      c_OP_XOR: w_result = x ^ y;
      default: begin
        w_result = 16'h0000;
      end
    endcase
  end

  // Zero is taken from the final selected result, so reserved ops report 1.
  assign w_zero = (w_result == 16'h0000);

  //--------------------------------------------------------------------------
  // Output registers
  //--------------------------------------------------------------------------
  logic [15:0] r_result;
  logic        r_zero;
  logic        r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= c_RESULT_RST;
      r_zero   <= c_ZERO_RST;
      r_carry  <= c_CARRY_RST;
    end else begin
      r_result <= w_result;
      r_zero   <= w_zero;
      r_carry  <= w_carry;
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign carry  = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_alu16.sv
//------------------------------------------------------------------------------
// Module   : tb_alu16
// Purpose  : Self-checking bench for alu16. Directed vectors plus randomized
//            operations compared against an arithmetic reference model; also
//            checks one-cycle latency, input isolation between edges and
//            asynchronous reset. Honours `ALU_DIV_EN the same way the design
//            does.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  op;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] result;
  logic        zero;
  logic        carry;

  int n_checks = 0;
  int n_errors = 0;

  alu16 u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .op     (op),
    .x      (x),
    .y      (y),
    .result (result),
    .zero   (zero),
    .carry  (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {zero, carry, result} from plain integer arithmetic.
  function automatic logic [17:0] ref_alu(input logic [3:0] f_op,
                                          input logic [15:0] f_x,
                                          input logic [15:0] f_y);
    longint a = f_x;
    longint b = f_y;
    longint r = 0;
    logic   c = 1'b0;
    case (f_op)
      4'h0: begin r = (a + b) % 65536; c = (a + b) > 65535; end
      4'h1: begin r = (a - b + 65536) % 65536; c = (b > a); end
      4'h2: r = (a * b) % 65536;
`ifdef ALU_DIV_EN
      4'h3: begin
        if (b == 0) begin r = 65535; c = 1'b1; end
        else r = a / b;
      end
`endif
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      default: r = 0;
    endcase
    return {(r == 0), c, r[15:0]};
  endfunction

  // Present operands at the falling edge, check one rising edge later.
  task automatic run_op(input string tag, input logic [3:0] t_op,
                        input logic [15:0] t_x, input logic [15:0] t_y,
                        input logic [15:0] e_res, input logic e_zero,
                        input logic e_carry);
    @(negedge clk);
    op = t_op; x = t_x; y = t_y;
    @(posedge clk);
    #1;
    check({tag, ".result"}, 32'(result), 32'(e_res));
    check({tag, ".zero"},   32'(zero),   32'(e_zero));
    check({tag, ".carry"},  32'(carry),  32'(e_carry));
  endtask

  task automatic run_model(input string tag, input logic [3:0] t_op,
                           input logic [15:0] t_x, input logic [15:0] t_y);
    logic [17:0] e;
    e = ref_alu(t_op, t_x, t_y);
    run_op(tag, t_op, t_x, t_y, e[15:0], e[17], e[16]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".result"}, 32'(result), 32'h0000);
    check({tag, ".zero"},   32'(zero),   32'h1);
    check({tag, ".carry"},  32'(carry),  32'h0);
  endtask

  initial begin
    logic [17:0] held;
    logic [3:0]  r_op_v;
    logic [15:0] r_x_v;
    logic [15:0] r_y_v;

    // Reset with arbitrary inputs applied and clock running
    rst_n = 1'b0;
    op = 4'h2; x = 16'hBEEF; y = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with literal expectations
    run_op("add",      4'h0, 16'h0123, 16'h1234, 16'h1357, 1'b0, 1'b0);
    run_op("sub_brw",  4'h1, 16'h0123, 16'h1234, 16'hEEEF, 1'b0, 1'b1);
    run_op("sub_zero", 4'h1, 16'h0123, 16'h0123, 16'h0000, 1'b1, 1'b0);
    run_op("add_wrap", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    run_op("mul",      4'h2, 16'h0123, 16'h1234, 16'hB11C, 1'b0, 1'b0);
`ifdef ALU_DIV_EN
    run_op("div",      4'h3, 16'h3E58, 16'h0078, 16'h0085, 1'b0, 1'b0);
    run_op("div_by0",  4'h3, 16'h3E58, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
`else
    run_op("div_off",  4'h3, 16'h3E58, 16'h0078, 16'h0000, 1'b1, 1'b0);
`endif
    run_op("and",      4'h4, 16'hAF74, 16'h7CC7, 16'h2C44, 1'b0, 1'b0);
    run_op("or",       4'h5, 16'hAF74, 16'h7CC7, 16'hFFF7, 1'b0, 1'b0);
    run_op("xor",      4'h6, 16'hAF74, 16'h7CC7, 16'hD3B3, 1'b0, 1'b0);
    for (int k = 7; k < 16; k++)
      run_op("reserved", 4'(k), 16'hAF74, 16'h7CC7, 16'h0000, 1'b1, 1'b0);

    // Randomized back-to-back ops; between edges the inputs are scrambled to
    // prove the outputs only move on the clock edge.
    for (int n = 0; n < 400; n++) begin
      r_op_v = 4'($urandom_range(0, 8));
      r_x_v  = 16'($urandom);
      r_y_v  = (n % 16 == 0) ? 16'h0000 : 16'($urandom);
      if (n % 8 == 1) r_y_v = r_x_v;
      run_model("rand", r_op_v, r_x_v, r_y_v);
      held = ref_alu(r_op_v, r_x_v, r_y_v);
      op = 4'($urandom); x = 16'($urandom); y = 16'($urandom);
      #2;
      check("hold.result", 32'(result), 32'(held[15:0]));
      check("hold.flags",  32'({zero, carry}), 32'(held[17:16]));
    end

    // Mid-stream asynchronous reset: outputs clear without a clock edge
    run_model("pre_rst", 4'h0, 16'hFFF0, 16'h0020);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    check_reset_vals("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_model("post_rst", 4'h2, 16'h00FF, 16'h0101);
    run_op("post_rst2", 4'h0, 16'h0123, 16'h1234, 16'h1357, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
